smvm_ctrl: RTL and testbench

SMVM_CTRL -- requirements
Module: smvm_ctrl

---
 rtl/smvm_ctrl_if.sv | 30 +++
 rtl/smvm_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_smvm_ctrl.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/smvm_ctrl_if.sv
// Stream-in, vector-buffer write and ALU issue signals of smvm_ctrl.
// master = beat producer / ALU side, slave = smvm_ctrl.
interface smvm_ctrl_if #(parameter int K = 4) ();
    logic              in_valid;
    logic              in_ready;
    logic [7:0]        val_in;
    logic [7:0]        col_in;
    logic              ipv_in;
    logic              vec_we;
    logic [6:0]        vec_addr;
    logic [7:0]        vec_wdata;
    logic              issue_valid;
    logic              issue_ready;
    logic [K-1:0][7:0] issue_val;
    logic [K-1:0][7:0] issue_col;
    logic [K-1:0]      issue_mask;
    logic [K-1:0]      issue_rowend;
    logic [7:0]        issue_row;

    modport master (
        output in_valid, val_in, col_in, ipv_in, issue_ready,
        input  in_ready, vec_we, vec_addr, vec_wdata, issue_valid,
               issue_val, issue_col, issue_mask, issue_rowend, issue_row
    );
    modport slave (
        input  in_valid, val_in, col_in, ipv_in, issue_ready,
        output in_ready, vec_we, vec_addr, vec_wdata, issue_valid,
               issue_val, issue_col, issue_mask, issue_rowend, issue_row
    );
endinterface

// File: rtl/smvm_ctrl.sv
// Sparse matrix-vector stream controller: header, vector load, CSR beats packed into K-lane ALU groups.
// Optional statistics counters enabled by defining SMVM_CTRL_STAT_EN.

module smvm_lane (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_i,
    input  logic       ld_i,
    input  logic       keep_i,
    input  logic [7:0] val_i,
    input  logic [7:0] col_i,
    input  logic       msk_i,
    input  logic       end_i,
    output logic [7:0] val_o,
    output logic [7:0] col_o,
    output logic       msk_o,
    output logic       end_o
);
    logic [7:0] sval_q, scol_q, val_q, col_q;
    logic       smsk_q, send_q, msk_q, end_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {sval_q, scol_q, smsk_q, send_q} <= '0;
            {val_q, col_q, msk_q, end_q}     <= '0;
        end else begin
            if (wr_i) {sval_q, scol_q, smsk_q, send_q} <= {val_i, col_i, msk_i, end_i};
            // On group load a lane takes the live beat, its staged beat, or blanks if unfilled.
            if (ld_i) begin
                if (wr_i)        {val_q, col_q, msk_q, end_q} <= {val_i, col_i, msk_i, end_i};
                else if (keep_i) {val_q, col_q, msk_q, end_q} <= {sval_q, scol_q, smsk_q, send_q};
                else             {val_q, col_q, msk_q, end_q} <= '0;
            end
        end
    end

    assign {val_o, col_o, msk_o, end_o} = {val_q, col_q, msk_q, end_q};
endmodule

module smvm_ctrl #(parameter int K = 4) (
    input  logic        clk,
    input  logic        rst_n,
    smvm_ctrl_if.slave  bus,
    output logic [7:0]  rows_o,
    output logic [7:0]  cols_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_hdr_o,
    output logic        err_col_o,
    output logic [15:0] nnz_cnt_o,
    output logic [15:0] stall_cnt_o
);
    localparam int FW = $clog2(K);
    typedef enum logic [2:0] {IDLE, VEC_IN, MAT_IN, DRAIN, DONE} state_t;

    state_t            state_q;
    logic [7:0]        rows_q, cols_q, vec_cnt_q, row_cnt_q, fill_row_q, issue_row_q;
    logic [FW-1:0]     fill_cnt_q;
    logic              busy_q, done_q, err_hdr_q, err_col_q, issue_valid_q;
    logic              in_rdy, acc, hdr_ok, hdr_go, acc_mat, col_ok, last_beat, grp_ld;
    logic [K-1:0][7:0] iss_val, iss_col;
    logic [K-1:0]      iss_msk, iss_end;

    always_comb begin
        in_rdy = 1'b0;
        case (state_q)
            IDLE, VEC_IN: in_rdy = 1'b1;
            MAT_IN:       in_rdy = !(issue_valid_q && !bus.issue_ready);
            default:      in_rdy = 1'b0;
        endcase
    end

    assign acc       = bus.in_valid && in_rdy;
    assign hdr_ok    = (bus.val_in != 8'd0) && (bus.col_in != 8'd0) && (bus.col_in <= 8'd128);
    assign hdr_go    = acc && (state_q == IDLE) && hdr_ok;
    assign acc_mat   = acc && (state_q == MAT_IN);
    assign col_ok    = bus.col_in < cols_q;
    assign last_beat = acc_mat && bus.ipv_in && (row_cnt_q == rows_q - 8'd1);
    assign grp_ld    = acc_mat && ((fill_cnt_q == FW'(K-1)) || last_beat);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rows_q    <= '0;
            cols_q    <= '0;
            vec_cnt_q <= '0;
            row_cnt_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_hdr_q <= 1'b0;
            err_col_q <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            err_hdr_q <= 1'b0;
            case (state_q)
                IDLE: if (acc) begin
                    if (hdr_ok) begin
                        rows_q    <= bus.val_in;
                        cols_q    <= bus.col_in;
                        vec_cnt_q <= '0;
                        row_cnt_q <= '0;
                        err_col_q <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= VEC_IN;
                    end else begin
                        err_hdr_q <= 1'b1;
                    end
                end
                VEC_IN: if (acc) begin
                    vec_cnt_q <= vec_cnt_q + 8'd1;
                    if (vec_cnt_q == cols_q - 8'd1) state_q <= MAT_IN;
                end
                MAT_IN: if (acc) begin
                    if (!col_ok)    err_col_q <= 1'b1;
                    if (bus.ipv_in) row_cnt_q <= row_cnt_q + 8'd1;
                    if (last_beat)  state_q   <= DRAIN;
                end
                DRAIN: if (!issue_valid_q) begin
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Group registers reload on the completing beat even while the old group retires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_cnt_q    <= '0;
            fill_row_q    <= '0;
            issue_row_q   <= '0;
            issue_valid_q <= 1'b0;
        end else begin
            if (hdr_go || grp_ld) fill_cnt_q <= '0;
            else if (acc_mat)     fill_cnt_q <= fill_cnt_q + 1'b1;
            if (acc_mat && fill_cnt_q == '0) fill_row_q <= row_cnt_q;
            if (grp_ld) begin
                issue_valid_q <= 1'b1;
                issue_row_q   <= (fill_cnt_q == '0) ? row_cnt_q : fill_row_q;
            end else if (bus.issue_ready) begin
                issue_valid_q <= 1'b0;
            end
        end
    end

    for (genvar i = 0; i < K; i++) begin : g_lane
        smvm_lane u_lane (
            .clk    (clk),
            .rst_n  (rst_n),
            .wr_i   (acc_mat && fill_cnt_q == FW'(i)),
            .ld_i   (grp_ld),
            .keep_i (fill_cnt_q > FW'(i)),
            .val_i  (bus.val_in),
            .col_i  (bus.col_in),
            .msk_i  (col_ok),
            .end_i  (bus.ipv_in),
            .val_o  (iss_val[i]),
            .col_o  (iss_col[i]),
            .msk_o  (iss_msk[i]),
            .end_o  (iss_end[i])
        );
    end

`ifdef SMVM_CTRL_STAT_EN
    logic [15:0] nnz_q, stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nnz_q   <= '0;
            stall_q <= '0;
        end else if (hdr_go) begin
            nnz_q   <= '0;
            stall_q <= '0;
        end else begin
            if (acc_mat && col_ok && nnz_q != 16'hFFFF) nnz_q <= nnz_q + 16'd1;
            if (issue_valid_q && !bus.issue_ready && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
        end
    end

    assign nnz_cnt_o   = nnz_q;
    assign stall_cnt_o = stall_q;
`else
    assign nnz_cnt_o   = 16'd0;
    assign stall_cnt_o = 16'd0;
`endif

    assign bus.in_ready     = in_rdy;
    assign bus.vec_we       = (state_q == VEC_IN) && bus.in_valid;
    assign bus.vec_addr     = vec_cnt_q[6:0];
    assign bus.vec_wdata    = bus.val_in;
    assign bus.issue_valid  = issue_valid_q;
    assign bus.issue_val    = iss_val;
    assign bus.issue_col    = iss_col;
    assign bus.issue_mask   = iss_msk;
    assign bus.issue_rowend = iss_end;
    assign bus.issue_row    = issue_row_q;
    assign rows_o           = rows_q;
    assign cols_o           = cols_q;
    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign err_hdr_o        = err_hdr_q;
    assign err_col_o        = err_col_q;
endmodule

// File: tb/tb_smvm_ctrl.sv
// Directed bench for smvm_ctrl: a beat-level reference model predicts vector writes and
// issued groups, a negedge monitor compares them, and literal checks pin key results.
module tb_smvm_ctrl;
    localparam int K   = 4;
    localparam int HDR = 0, VEC = 1, MAT = 2;
`ifdef SMVM_CTRL_STAT_EN
    localparam bit STAT = 1'b1;
`else
    localparam bit STAT = 1'b0;
`endif

    typedef struct packed {
        logic [K-1:0][7:0] val;
        logic [K-1:0][7:0] col;
        logic [K-1:0]      mask;
        logic [K-1:0]      rowend;
        logic [7:0]        row;
    } grp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rows, cols;
    logic        busy, done, err_hdr, err_col;
    logic [15:0] nnz_cnt, stall_cnt;

    smvm_ctrl_if #(.K(K)) bus_if ();

    smvm_ctrl #(.K(K)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus_if),
        .rows_o(rows), .cols_o(cols), .busy_o(busy), .done_o(done),
        .err_hdr_o(err_hdr), .err_col_o(err_col),
        .nnz_cnt_o(nnz_cnt), .stall_cnt_o(stall_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0, done_cnt = 0;

    // reference model state
    grp_t        exp_q[$], got_q[$];
    logic [14:0] vexp_q[$];
    grp_t        m_grp;
    int          m_n, m_row, m_rows, m_cols, m_vaddr, m_nnz, m_stall;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_hdr(input logic [7:0] v, input logic [7:0] c);
        if (v >= 1 && c >= 1 && c <= 128) begin
            m_rows = v; m_cols = c; m_row = 0; m_n = 0; m_grp = '0;
            m_vaddr = 0; m_nnz = 0; m_stall = 0;
        end
    endtask

    // A row of the matrix is closed by ipv; the group closes when full or the last row closes.
    task automatic model_beat(input logic [7:0] v, input logic [7:0] c, input logic ipv);
        if (m_n == 0) m_grp.row = 8'(m_row);
        m_grp.val[m_n]    = v;
        m_grp.col[m_n]    = c;
        m_grp.mask[m_n]   = (int'(c) < m_cols);
        m_grp.rowend[m_n] = ipv;
        if (int'(c) < m_cols) m_nnz++;
        m_n++;
        if (ipv) m_row++;
        if (m_n == K || (ipv && m_row == m_rows)) begin
            exp_q.push_back(m_grp);
            m_grp = '0;
            m_n = 0;
        end
    endtask

    task automatic send(input logic [7:0] v, input logic [7:0] c, input logic ipv, input int ph);
        bit ok = 1'b0;
        bus_if.in_valid = 1'b1;
        bus_if.val_in   = v;
        bus_if.col_in   = c;
        bus_if.ipv_in   = ipv;
        if (ph == VEC) begin
            vexp_q.push_back({7'(m_vaddr), v});
            m_vaddr++;
        end
        repeat (50) begin
            @(negedge clk);
            if (bus_if.in_ready) begin ok = 1'b1; break; end
        end
        chk("beat accepted", ok, 1'b1);
        if (ok) begin
            @(posedge clk);
            if (ph == HDR) model_hdr(v, c);
            if (ph == MAT) model_beat(v, c, ipv);
        end
        #1 bus_if.in_valid = 1'b0;
    endtask

    task automatic wait_done(input int d0);
        bit ok = 1'b0;
        repeat (200) begin
            @(posedge clk);
            if (done_cnt > d0 && !busy) begin ok = 1'b1; break; end
        end
        chk("done reached", ok, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk("done pulse count", done_cnt - d0, 1);
        chk("all groups issued", exp_q.size(), 0);
        chk("all vec writes seen", vexp_q.size(), 0);
        chk("nnz_cnt", nnz_cnt, STAT ? m_nnz : 0);
    endtask

    task automatic pulse_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst issue_valid", bus_if.issue_valid, 1'b0);
        chk("rst busy", busy, 1'b0);
        chk("rst shape", {rows, cols}, 16'h0);
        chk("rst issue bus", {bus_if.issue_val, bus_if.issue_mask, bus_if.issue_row}, '0);
        chk("rst in_ready idle", bus_if.in_ready, 1'b1);
        exp_q.delete(); vexp_q.delete(); m_n = 0; m_grp = '0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        grp_t cur;
        if (rst_n) begin
            if (bus_if.vec_we) begin
                if (vexp_q.size() == 0) chk("unexpected vec_we", bus_if.vec_we, 1'b0);
                else begin
                    chk("vec write", {bus_if.vec_addr, bus_if.vec_wdata}, vexp_q[0]);
                    void'(vexp_q.pop_front());
                end
            end
            if (bus_if.issue_valid) begin
                cur.val = bus_if.issue_val; cur.col = bus_if.issue_col;
                cur.mask = bus_if.issue_mask; cur.rowend = bus_if.issue_rowend;
                cur.row = bus_if.issue_row;
                if (exp_q.size() == 0) chk("unexpected group", bus_if.issue_valid, 1'b0);
                else begin
                    chk("issued group", cur, exp_q[0]);
                    if (bus_if.issue_ready) begin
                        got_q.push_back(cur);
                        void'(exp_q.pop_front());
                    end
                end
                if (!bus_if.issue_ready) m_stall++;
            end
            if (done) done_cnt++;
        end
    end

    initial begin
        grp_t g0, g1;
        int d0;
        rst_n = 1'b0;
        bus_if.in_valid = 1'b0; bus_if.val_in = '0; bus_if.col_in = '0; bus_if.ipv_in = 1'b0;
        bus_if.issue_ready = 1'b1;
        m_grp = '0; m_n = 0; m_row = 0; m_rows = 0; m_cols = 0; m_vaddr = 0; m_nnz = 0; m_stall = 0;
        #2;
        chk("reset flags", {busy, done, err_hdr, err_col, bus_if.issue_valid, bus_if.vec_we}, 6'b0);
        chk("reset shape", {rows, cols}, 16'h0);
        chk("reset issue bus", {bus_if.issue_val, bus_if.issue_col, bus_if.issue_mask, bus_if.issue_rowend}, '0);
        chk("reset stats", {nnz_cnt, stall_cnt}, 32'h0);
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic 3x4 matrix, ALU always ready
        got_q.delete(); d0 = done_cnt;
        send(8'd3, 8'd4, 1'b0, HDR);
        chk("A busy after header", busy, 1'b1);
        for (int i = 0; i < 4; i++) send(8'(10 + i), 8'd0, 1'b0, VEC);
        send(8'd1, 8'd0, 1'b0, MAT); send(8'd2, 8'd1, 1'b1, MAT);
        send(8'd3, 8'd2, 1'b0, MAT); send(8'd4, 8'd3, 1'b1, MAT);
        send(8'd5, 8'd0, 1'b0, MAT); send(8'd6, 8'd1, 1'b1, MAT);
        wait_done(d0);
        chk("A shape", {rows, cols}, {8'd3, 8'd4});
        chk("A group count", got_q.size(), 2);
        g0 = got_q.size() > 0 ? got_q[0] : '0;
        g1 = got_q.size() > 1 ? got_q[1] : '0;
        chk("A g0 mask/rowend/row", {g0.mask, g0.rowend, g0.row}, {4'b1111, 4'b1010, 8'd0});
        chk("A g0 vals", g0.val, 32'h04030201);
        chk("A g1 mask/rowend/row", {g1.mask, g1.rowend, g1.row}, {4'b0011, 4'b0010, 8'd2});
        chk("A g1 vals", g1.val, 32'h00000605);

        // Bad column, stalled full group, then back-to-back final partial group
        got_q.delete(); d0 = done_cnt;
        send(8'd2, 8'd8, 1'b0, HDR);
        for (int i = 0; i < 8; i++) send(8'(20 + i), 8'd0, 1'b0, VEC);
        bus_if.issue_ready = 1'b0;
        send(8'd1, 8'd0, 1'b0, MAT); send(8'd2, 8'd1, 1'b0, MAT);
        send(8'd3, 8'd9, 1'b0, MAT); send(8'd4, 8'd3, 1'b1, MAT);
        chk("C err_col set", err_col, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("C stall in_ready", bus_if.in_ready, 1'b0);
            chk("C stall valid", bus_if.issue_valid, 1'b1);
        end
        @(posedge clk);
        #1;
        chk("C stall_cnt", stall_cnt, STAT ? 16'd5 : 16'd0);
        chk("C stall_cnt model", stall_cnt, STAT ? m_stall : 0);
        bus_if.issue_ready = 1'b1;
        send(8'd5, 8'd7, 1'b1, MAT);
        chk("C b2b valid", bus_if.issue_valid, 1'b1);
        chk("C b2b row/mask", {bus_if.issue_row, bus_if.issue_mask}, {8'd1, 4'b0001});
        wait_done(d0);
        g0 = got_q.size() > 0 ? got_q[0] : '0;
        chk("C g0 mask/rowend/row", {g0.mask, g0.rowend, g0.row}, {4'b1011, 4'b1000, 8'd0});
        chk("C g0 bad lane col", g0.col[2], 8'd9);
        chk("C err_col sticky", err_col, 1'b1);

        // Abort with two lanes filled
        send(8'd2, 8'd4, 1'b0, HDR);
        chk("D err_col cleared", err_col, 1'b0);
        for (int i = 0; i < 4; i++) send(8'(30 + i), 8'd0, 1'b0, VEC);
        send(8'd1, 8'd0, 1'b0, MAT); send(8'd2, 8'd1, 1'b0, MAT);
        pulse_reset();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("D no issue after reset", {bus_if.issue_valid, busy}, 2'b00);
        end
        @(posedge clk);
        #1;

        // Header errors and largest legal header
        send(8'd0, 8'd5, 1'b0, HDR);
        @(negedge clk);
        chk("B err_hdr pulse", {err_hdr, busy}, 2'b10);
        @(negedge clk);
        chk("B err_hdr drops", {err_hdr, busy}, 2'b00);
        send(8'd5, 8'd129, 1'b0, HDR);
        @(negedge clk);
        chk("B cols 129 rejected", {err_hdr, busy}, 2'b10);
        @(posedge clk);
        #1;
        send(8'd255, 8'd128, 1'b0, HDR);
        chk("B max header", {busy, err_hdr, rows, cols}, {2'b10, 8'd255, 8'd128});
        pulse_reset();

        // Recovery after abort: single-element final group
        got_q.delete(); d0 = done_cnt;
        send(8'd1, 8'd2, 1'b0, HDR);
        send(8'd40, 8'd0, 1'b0, VEC); send(8'd41, 8'd0, 1'b0, VEC);
        send(8'd9, 8'd1, 1'b1, MAT);
        wait_done(d0);
        g0 = got_q.size() > 0 ? got_q[0] : '0;
        chk("E single group", {g0.mask, g0.rowend, g0.row, g0.val}, {4'b0001, 4'b0001, 8'd0, 32'h00000009});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
